// File: rtl/ibex_axi_slave_ram.sv
// AXI4 slave on-chip RAM terminating one Ibex AXI master port.
// One transaction in flight; reads and writes share a fair arbiter.
// Serves FIXED/INCR/WRAP bursts from a byte-strobed synchronous memory.
module ibex_axi_slave_ram #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR = '0,
  parameter int MEM_BYTES          = 65536
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                      s00_axi_awlen,
  input  logic [2:0]                      s00_axi_awsize,
  input  logic [1:0]                      s00_axi_awburst,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wlast,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic [2:0]                      s00_axi_arsize,
  input  logic [1:0]                      s00_axi_arburst,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IW    = ($clog2(MEM_BYTES) > 2) ? $clog2(MEM_BYTES) - 2 : 1;
  localparam int WORDS = (MEM_BYTES / 4 > 0) ? MEM_BYTES / 4 : 1;
  localparam logic [AW-1:0] MEM_BYTES_A = AW'(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01, BURST_WRAP = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  state_e                      state_q, state_d;
  logic                        awready_q, arready_q, rd_prio_q;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]               addr_q;
  logic [7:0]                  len_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic [8:0]                  cnt_q;
  logic [1:0]                  bresp_q, rresp_q;
  logic                        rvalid_q, rlast_q;
  logic [DW-1:0]               rdata_q;
  logic [DW-1:0]               mem_q [WORDS];

  logic          idle_free, grant_r, grant_w, aw_hs, ar_hs, w_hs, r_hs, rd_issue;
  logic          beat_last, in_range, burst_err;
  logic [AW:0]   offset;
  logic [IW-1:0] word_idx;
  logic [1:0]    beat_resp, w_resp;
  logic [AW-1:0] addr_nxt;

  // Next beat address for FIXED, INCR and WRAP bursts.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] step, mask;
    step = AW'(1) << size;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BURST_INCR: return a + step;
      BURST_WRAP: return (a & ~mask) | ((a + step) & mask);
      default:    return a;
    endcase
  endfunction

  assign idle_free = (state_q == IDLE) && !awready_q && !arready_q;
  assign grant_r   = idle_free && s00_axi_arvalid && (!s00_axi_awvalid || rd_prio_q);
  assign grant_w   = idle_free && s00_axi_awvalid && !grant_r;
  assign aw_hs     = awready_q && s00_axi_awvalid;
  assign ar_hs     = arready_q && s00_axi_arvalid;
  assign w_hs      = (state_q == WRITE) && s00_axi_wvalid;
  assign r_hs      = rvalid_q && s00_axi_rready;
  assign beat_last = (cnt_q == {1'b0, len_q});
  assign rd_issue  = (state_q == READ) && (!rvalid_q || s00_axi_rready) && (cnt_q <= {1'b0, len_q});

  assign offset    = {1'b0, addr_q} - {1'b0, MEM_BASE_ADDR};
  assign in_range  = !offset[AW] && (offset[AW-1:0] < MEM_BYTES_A);
  assign word_idx  = offset[IW+1:2];
  assign burst_err = (size_q > 3'd2) || (burst_q == 2'b11) ||
                     ((burst_q == BURST_WRAP) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign beat_resp = !in_range ? RESP_DECERR : (burst_err ? RESP_SLVERR : RESP_OKAY);
  // wlast only flags a protocol error; the beat counter alone ends the burst.
  assign w_resp    = !in_range ? RESP_DECERR :
                     ((burst_err || (s00_axi_wlast != beat_last)) ? RESP_SLVERR : RESP_OKAY);
  assign addr_nxt  = next_addr(addr_q, len_q, size_q, burst_q);

  // State register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (aw_hs) state_d = WRITE; else if (ar_hs) state_d = READ;
      WRITE:   if (w_hs && beat_last) state_d = WRESP;
      WRESP:   if (s00_axi_bready) state_d = IDLE;
      READ:    if (r_hs && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration, transaction context, write response and read output register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rd_prio_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      awready_q <= grant_w || (awready_q && !aw_hs);
      arready_q <= grant_r || (arready_q && !ar_hs);
      if (idle_free && s00_axi_awvalid && s00_axi_arvalid) rd_prio_q <= !rd_prio_q;
      if (aw_hs) begin
        id_q <= s00_axi_awid;   addr_q  <= s00_axi_awaddr;  len_q <= s00_axi_awlen;
        size_q <= s00_axi_awsize; burst_q <= s00_axi_awburst; cnt_q <= '0;
        bresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
        id_q <= s00_axi_arid;   addr_q  <= s00_axi_araddr;  len_q <= s00_axi_arlen;
        size_q <= s00_axi_arsize; burst_q <= s00_axi_arburst; cnt_q <= '0;
      end else if (w_hs) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 9'd1;
        if (w_resp > bresp_q) bresp_q <= w_resp;
      end else if (rd_issue) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 9'd1;
      end
      if (rd_issue) begin
        rvalid_q <= 1'b1;
        rresp_q  <= beat_resp;
        rlast_q  <= beat_last;
        rdata_q  <= (beat_resp == RESP_OKAY) ? mem_q[word_idx] : '0;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Byte-strobed RAM write; errored beats are dropped.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_hs && (w_resp == RESP_OKAY)) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (s00_axi_wstrb[b]) mem_q[word_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_wready  = (state_q == WRITE);
  assign s00_axi_bvalid  = (state_q == WRESP);
  assign s00_axi_bid     = id_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rid     = id_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rlast   = rlast_q;
  assign s00_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_ibex_axi_slave_ram.sv
// Scoreboard bench for ibex_axi_slave_ram: a byte-level reference memory
// produces expected B/R responses; a monitor pops and compares on handshakes.
module tb_ibex_axi_slave_ram;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          BYTES = 1024;

  logic        clk, aresetn;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  ibex_axi_slave_ram #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
                       .MEM_BASE_ADDR(BASE), .MEM_BYTES(BYTES)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen), .s00_axi_arsize(arsize),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready));

  int errors = 0, checks = 0, cyc = 0;
  int rmode = 1;
  int ar_cyc = -1, aw_cyc = -1, w_cyc = -1, b_first = -1, r_first = -1, r_last_cyc = -1;
  bit both_seen = 0;
  logic [7:0]  mem_m [BYTES];
  logic [2:0]  exp_b_q [$];
  logic [35:0] exp_r_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (rmode == 0) rready = ($urandom % 4) != 0;
    else rready = (rmode == 1);
    bready = ($urandom % 3) != 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++; errors++;
    $display("FAIL timeout waiting for %s", nm);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size, input int len,
                                            input int burst, input int i);
    longint unsigned bytes, wnd, lo;
    bytes = longint'(1) << size;
    wnd = longint'(len + 1) * bytes;
    case (burst)
      1: return 32'(longint'(start) + longint'(i) * bytes);
      2: begin
        lo = longint'(start) - (longint'(start) % wnd);
        return 32'(lo + ((longint'(start) - lo + longint'(i) * bytes) % wnd));
      end
      default: return start;
    endcase
  endfunction

  function automatic logic [1:0] resp_m(input logic [31:0] a, input int size, input int len, input int burst);
    if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + BYTES) return 2'b11;
    if (size > 2 || burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)))
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] word_m(input logic [31:0] a);
    int i;
    i = int'((a - BASE) / 4) * 4;
    return {mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
  endfunction

  // sel: 0 awready, 1 arready, 2 wready; returns at posedge+1 after the handshake edge
  task automatic wait_sig(input int sel, input string nm);
    int n = 0;
    logic s;
    forever begin
      @(negedge clk);
      s = (sel == 0) ? awready : (sel == 1) ? arready : wready;
      if (s) break;
      if (++n > 3000) begin timeout(nm); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic write_txn(input logic id, input logic [31:0] addr, input int len, input int size,
                           input int burst, input int wlast_beat);
    logic [1:0] worst, r;
    logic [31:0] a;
    int off;
    worst = 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      r = resp_m(a, size, len, burst);
      if ((i == wlast_beat) != (i == len) && r < 2'b10) r = 2'b10;
      if (r == 2'b00) begin
        off = int'((a - BASE) / 4) * 4;
        for (int b = 0; b < 4; b++) if (ws_q[i][b]) mem_m[off+b] = wd_q[i][8*b +: 8];
      end
      if (r > worst) worst = r;
    end
    exp_b_q.push_back({id, worst});
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1;
    wait_sig(0, "awready");
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1; wdata = wd_q[i]; wstrb = ws_q[i]; wlast = (i == wlast_beat);
      wait_sig(2, "wready");
    end
    wvalid = 0; wlast = 0;
    wd_q.delete(); ws_q.delete();
  endtask

  task automatic read_txn(input logic id, input logic [31:0] addr, input int len, input int size,
                          input int burst);
    logic [1:0] r;
    logic [31:0] a;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      r = resp_m(a, size, len, burst);
      exp_r_q.push_back({id, 1'(i == len), r, (r == 2'b00) ? word_m(a) : 32'h0});
    end
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1;
    wait_sig(1, "arready");
    arvalid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      @(negedge clk);
      if (++n > 5000) begin timeout("responses"); exp_b_q.delete(); exp_r_q.delete(); end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    wd_q.push_back(d); ws_q.push_back(s);
    write_txn(0, addr, 0, 2, 1, 0);
  endtask

  task automatic rand_txn();
    int sel, burst, size, len, wl;
    logic [31:0] addr;
    sel = $urandom % 16;
    burst = (sel < 2) ? 0 : (sel < 10) ? 1 : (sel < 15) ? 2 : 3;
    size = (($urandom % 8) < 6) ? 2 : int'($urandom % 2);
    if ($urandom % 20 == 0) size = 3;
    case (burst)
      0: len = $urandom % 4;
      1: len = $urandom % 16;
      2: begin
        case ($urandom % 5) 0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2; endcase
      end
      default: len = $urandom % 4;
    endcase
    addr = BASE + ($urandom % (BYTES / 4)) * 4;
    if ($urandom % 16 == 0) addr = (($urandom % 2) != 0) ? BASE + BYTES + 32'h40 : BASE - 32'h40;
    if (($urandom % 2) != 0) begin
      for (int i = 0; i <= len; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'($urandom)); end
      wl = (($urandom % 8) == 0) ? $urandom_range(0, len + 1) : len;
      write_txn(1'($urandom), addr, len, size, burst, wl);
    end else begin
      read_txn(1'($urandom), addr, len, size, burst);
    end
  endtask

  // Monitor: compares every B/R handshake against the scoreboard queues.
  logic [34:0] held;
  bit hold = 0;
  initial forever begin
    @(negedge clk);
    if (!aresetn) hold = 0;
    else begin
      if (awready && arready) both_seen = 1;
      if (hold) begin
        chk("r_stable", {rvalid, rdata, rresp, rlast}, {1'b1, held});
        hold = 0;
      end
      if (arvalid && arready) ar_cyc = cyc;
      if (awvalid && awready) aw_cyc = cyc;
      if (wvalid && wready) w_cyc = cyc;
      if (bvalid && b_first < 0) b_first = cyc;
      if (rvalid && r_first < 0) r_first = cyc;
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin checks++; errors++; $display("FAIL b_unexpected: bresp %b", bresp); end
        else chk("b_resp", {61'b0, bid, bresp}, {61'b0, exp_b_q.pop_front()});
      end
      if (rvalid && rready) begin
        r_last_cyc = cyc;
        if (exp_r_q.size() == 0) begin checks++; errors++; $display("FAIL r_unexpected: rdata %h", rdata); end
        else chk("r_beat", {28'b0, rid, rlast, rresp, rdata}, {28'b0, exp_r_q.pop_front()});
      end
      if (rvalid && !rready) begin hold = 1; held = {rdata, rresp, rlast}; end
    end
  end

  initial begin
    int n, c0;
    aresetn = 0; awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0; bready = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", {61'b0, awready, arready, wready}, 64'd0);
    chk("rst_valid", {60'b0, bvalid, rvalid, rlast, 1'b0}, 64'd0);
    chk("rst_b", {61'b0, bid, bresp}, 64'd0);
    chk("rst_r", {29'b0, rid, rresp, rdata}, 64'd0);
    aresetn = 1;
    @(posedge clk); #1;

    // fill the whole RAM so every later read is defined
    for (int i = 0; i < BYTES / 4; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    write_txn(0, BASE, BYTES / 4 - 1, 2, 1, BYTES / 4 - 1);
    drain();

    // single write / read, B latency
    b_first = -1;
    wr1(BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    drain();
    chk("b_latency", 64'(b_first), 64'(w_cyc + 1));
    read_txn(0, BASE + 32'h10, 0, 2, 1);
    drain();

    // partial strobe
    wr1(BASE + 32'h20, 32'h11223344, 4'hF);
    wr1(BASE + 32'h20, 32'hAABBCCDD, 4'h5);
    read_txn(1, BASE + 32'h20, 0, 2, 1);
    drain();

    // INCR 8 beats, back-to-back read timing
    for (int i = 0; i < 8; i++) begin wd_q.push_back(i); ws_q.push_back(4'hF); end
    write_txn(0, BASE + 32'h100, 7, 2, 1, 7);
    drain();
    rmode = 1; r_first = -1;
    read_txn(1, BASE + 32'h100, 7, 2, 1);
    drain();
    chk("r_latency", 64'(r_first), 64'(ar_cyc + 2));
    chk("r_b2b", 64'(r_last_cyc - r_first), 64'd7);

    // WRAP read with 3-cycle rready stall
    read_txn(0, BASE + 32'h108, 3, 2, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 100);
    if (!rvalid) timeout("rvalid");
    @(posedge clk); #1 rmode = 2;
    repeat (3) @(posedge clk);
    #1 rmode = 1;
    drain();

    // error cases
    wr1(BASE + BYTES, 32'h12345678, 4'hF);
    wr1(BASE - 4, 32'h87654321, 4'hF);
    read_txn(0, BASE, 0, 2, 1);
    read_txn(0, BASE + 32'h40, 0, 3, 1);
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA0 + i); ws_q.push_back(4'hF); end
    write_txn(1, BASE + 32'h200, 3, 2, 1, 1);
    read_txn(1, BASE + 32'h200, 3, 2, 1);
    read_txn(0, BASE + 32'h80, 1, 2, 3);
    for (int i = 0; i < 3; i++) begin wd_q.push_back(32'hB0 + i); ws_q.push_back(4'hF); end
    write_txn(0, BASE + 32'h240, 2, 2, 2, 2);
    read_txn(0, BASE + 32'h240, 3, 2, 1);
    read_txn(1, BASE + BYTES - 8, 3, 2, 1);
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hC0 + i); ws_q.push_back(4'hF); end
    write_txn(0, BASE + 32'h300, 3, 2, 0, 3);
    read_txn(0, BASE + 32'h300, 1, 2, 0);
    drain();

    // AW/AR contention: grants alternate starting with read
    for (int k = 0; k < 4; k++) begin
      wd_q.push_back($urandom); ws_q.push_back(4'hF);
      fork
        write_txn(0, BASE + 32'h380 + 32'(k * 4), 0, 2, 1, 0);
        read_txn(1, BASE + 32'h3C0 + 32'(k * 4), 0, 2, 1);
      join
      drain();
      chk("grant_order", 64'(ar_cyc < aw_cyc), 64'((k % 2) == 0));
    end

    // randomized traffic with random backpressure
    rmode = 0;
    for (int t = 0; t < 80; t++) rand_txn();
    drain();

    // reset mid-burst
    rmode = 2;
    read_txn(0, BASE, 15, 2, 1);
    repeat (4) @(posedge clk);
    #1 aresetn = 0;
    #1 chk("midrst_outputs", {58'b0, awready, arready, wready, bvalid, rvalid, rlast}, 64'd0);
    exp_r_q.delete();
    rmode = 1;
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
    c0 = cyc;
    wr1(BASE + 32'h44, 32'h5A5AA5A5, 4'hF);
    chk("post_rst_accept", 64'(aw_cyc), 64'(c0 + 1));
    read_txn(1, BASE + 32'h44, 0, 2, 1);
    drain();

    chk("single_ready", 64'(both_seen), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
